// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional oversample/bit/mid-bit tick generator for the UART.
// Divisor is shadowed and handed over at a tick boundary; sync_req re-phases RX.
module baud_tick_gen #(
    parameter int unsigned SYS_CLK_FREQ = 100000000,
    parameter int unsigned DEFAULT_BAUD = 9600,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    input  logic                          sync_req,
    output logic                          div_pend,
    output logic                          tick_os,
    output logic                          tick_bit,
    output logic                          tick_mid,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int unsigned PH_W = $clog2(OVERSAMPLE);

    // Reset divisor derived from the clock and default baud rate.
    localparam logic [63:0] TICK_RATE =
        64'(DEFAULT_BAUD) * 64'(OVERSAMPLE);
    localparam logic [63:0] DEF_I_64 =
        64'(SYS_CLK_FREQ) / TICK_RATE;
    localparam logic [63:0] DEF_F_64 =
        (64'(SYS_CLK_FREQ) << FRAC_W) / TICK_RATE;

    localparam logic [DIV_W-1:0]  DEF_INT  = DEF_I_64[DIV_W-1:0];
    localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_F_64[FRAC_W-1:0];

    localparam logic [DIV_W-1:0] DEF_EFF =
        (DEF_INT < DIV_W'(2)) ? DIV_W'(2) : DEF_INT;
    localparam logic [DIV_W-1:0] DEF_CNT = DEF_EFF - DIV_W'(1);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);

    // Active divisor, used by the running counter.
    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;

    // Shadow divisor, written by div_load.
    logic [DIV_W-1:0]  sh_int;
    logic [FRAC_W-1:0] sh_frac;

    // Period counter and fractional accumulator.
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;

    // Next-state helpers.
    logic              reload;
    logic              use_sh;
    logic [DIV_W-1:0]  i_sel;
    logic [FRAC_W-1:0] f_sel;
    logic [DIV_W-1:0]  i_eff;
    logic [DIV_W-1:0]  cnt_base;
    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W-1:0]  cnt_reload;

    // Pick the divisor for this edge: the shadow takes over whenever the
    // counter is re-seeded (reload, resync or idle), so a change never
    // truncates or stretches a period already in flight.
    always_comb begin
        reload   = en & ~sync_req & (cnt == '0);
        use_sh   = div_pend & (reload | ~en | sync_req);
        i_sel    = use_sh ? sh_int  : act_int;
        f_sel    = use_sh ? sh_frac : act_frac;
        i_eff    = (i_sel < DIV_W'(2)) ? DIV_W'(2) : i_sel;
        cnt_base = i_eff - DIV_W'(1);
        acc_sum  = {1'b0, acc} + {1'b0, f_sel};
        cnt_reload = cnt_base + DIV_W'(acc_sum[FRAC_W]);
    end

    // Shadow capture and hand-over of the shadow into the active divisor.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_int   <= DEF_INT;
            sh_frac  <= DEF_FRAC;
            act_int  <= DEF_INT;
            act_frac <= DEF_FRAC;
            div_pend <= 1'b0;
        end else begin
            if (use_sh) begin
                act_int  <= sh_int;
                act_frac <= sh_frac;
            end
            if (div_load) begin
                sh_int   <= div_int;
                sh_frac  <= div_frac;
                div_pend <= 1'b1;
            end else if (use_sh) begin
                div_pend <= 1'b0;
            end
        end
    end

    // Period counter, fractional carry and registered tick generation.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= DEF_CNT;
            acc      <= '0;
            os_phase <= '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
            tick_mid <= 1'b0;
        end else if (!en || sync_req) begin
            cnt      <= cnt_base;
            acc      <= '0;
            os_phase <= '0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
            tick_mid <= 1'b0;
        end else if (reload) begin
            cnt      <= cnt_reload;
            acc      <= acc_sum[FRAC_W-1:0];
            os_phase <= os_phase + PH_W'(1);
            tick_os  <= 1'b1;
            tick_bit <= (os_phase == PH_LAST);
            tick_mid <= (os_phase == PH_MID);
        end else begin
            cnt      <= cnt - DIV_W'(1);
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
            tick_mid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed bench for baud_tick_gen.
// Tick times are taken as the index of the clock edge that produced them.
module tb_baud_tick_gen;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        sync_req;
    logic        div_pend;
    logic        tick_os;
    logic        tick_bit;
    logic        tick_mid;
    logic [3:0]  os_phase;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc_cnt  = 0;

    longint r0, t0, t1, t2, tm, tm2, tb, tb2, tp, tn, ta, tx, s0;

    baud_tick_gen dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .sync_req (sync_req),
        .div_pend (div_pend),
        .tick_os  (tick_os),
        .tick_bit (tick_bit),
        .tick_mid (tick_mid),
        .os_phase (os_phase)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // sel: 0 = tick_os, 1 = tick_mid, 2 = tick_bit
    task automatic wait_ev(input int sel, input int budget, output longint t);
        logic hit;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            hit = (sel == 0) ? tick_os : (sel == 1) ? tick_mid : tick_bit;
            if (hit) begin
                t = cyc_cnt;
                break;
            end
        end
        n_checks++;
        assert (t >= 0) else begin
            n_fail++;
            $error("FAIL timeout sel=%0d observed=none expected=event in %0d",
                   sel, budget);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        div_int  = '0;
        div_frac = '0;
        div_load = 1'b0;
        sync_req = 1'b0;

        // Reset state
        step(3);
        chk("rst_tick_os", tick_os, 0);
        chk("rst_tick_bit", tick_bit, 0);
        chk("rst_tick_mid", tick_mid, 0);
        chk("rst_div_pend", div_pend, 0);
        chk("rst_os_phase", os_phase, 0);

        // Default divisor 651/0
        rst_n = 1'b1;
        r0 = cyc_cnt;
        wait_ev(0, 700, t1);
        chk("def_first_os", t1 - r0, 651);
        chk("def_phase1", os_phase, 1);
        step(1);
        chk("def_os_width", tick_os, 0);
        wait_ev(0, 700, t2);
        chk("def_os_period", t2 - t1, 651);
        wait_ev(1, 12000, tm);
        chk("def_first_mid", tm - r0, 5208);
        wait_ev(2, 12000, tb);
        chk("def_first_bit", tb - r0, 10416);
        chk("def_bit_phase", os_phase, 0);
        wait_ev(1, 12000, tm2);
        wait_ev(2, 12000, tb2);
        chk("def_bit_period", tb2 - tb, 10416);
        chk("def_mid_lead", tb2 - tm2, 5208);

        // Fractional divisor 10 + 4/16
        div_int  = 16'd10;
        div_frac = 4'd4;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        chk("frac_pend_set", div_pend, 1);
        wait_ev(0, 700, t0);
        chk("frac_old_period", t0 - tb2, 651);
        chk("frac_pend_clr", div_pend, 0);
        tp = t0;
        for (int i = 0; i < 16; i++) begin
            wait_ev(0, 30, tn);
            chk("frac_period", tn - tp, (i % 4 == 3) ? 11 : 10);
            tp = tn;
        end
        chk("frac_span16", tp - t0, 164);

        // Load 20 three cycles into a 10-cycle period
        step(3);
        div_int  = 16'd20;
        div_frac = 4'd0;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        chk("mid_pend_set", div_pend, 1);
        wait_ev(0, 30, ta);
        chk("mid_cur_period", ta - tp, 10);
        chk("mid_pend_clr", div_pend, 0);
        wait_ev(0, 40, tn);
        chk("mid_new_period", tn - ta, 20);

        // Sync at os_phase 9
        for (int i = 0; i < 20 && os_phase != 4'd9; i++) wait_ev(0, 40, tx);
        chk("sync_at_phase9", os_phase, 9);
        sync_req = 1'b1;
        step(1);
        sync_req = 1'b0;
        s0 = cyc_cnt;
        chk("sync_phase0", os_phase, 0);
        chk("sync_no_tick", tick_os, 0);
        wait_ev(0, 40, tn);
        chk("sync_first_os", tn - s0, 20);
        wait_ev(1, 200, tm);
        chk("sync_mid_8th", tm - s0, 160);

        // Sync on the same edge as a reload
        step(19);
        sync_req = 1'b1;
        step(1);
        sync_req = 1'b0;
        s0 = cyc_cnt;
        chk("sync2_no_tick", tick_os, 0);
        chk("sync2_phase0", os_phase, 0);
        wait_ev(0, 40, tn);
        chk("sync2_first_os", tn - s0, 20);
        wait_ev(1, 200, tm);
        chk("sync2_mid_8th", tm - s0, 160);

        // Clamp div_int 0
        div_int  = 16'd0;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        wait_ev(0, 40, tp);
        for (int i = 0; i < 3; i++) begin
            wait_ev(0, 5, tn);
            chk("clamp0_period", tn - tp, 2);
            tp = tn;
        end
        step(1);
        chk("clamp0_low", tick_os, 0);

        // Clamp div_int 1
        div_int  = 16'd1;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        wait_ev(0, 5, tp);
        for (int i = 0; i < 3; i++) begin
            wait_ev(0, 5, tn);
            chk("clamp1_period", tn - tp, 2);
            tp = tn;
        end
        step(1);
        chk("clamp1_low", tick_os, 0);

        // Reset while a shadow is pending
        div_int  = 16'd50;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        chk("rst2_pend_set", div_pend, 1);
        rst_n = 1'b0;
        #1;
        chk("rst2_pend", div_pend, 0);
        chk("rst2_tick_os", tick_os, 0);
        chk("rst2_tick_bit", tick_bit, 0);
        chk("rst2_tick_mid", tick_mid, 0);
        chk("rst2_phase", os_phase, 0);
        step(2);
        rst_n = 1'b1;
        r0 = cyc_cnt;
        wait_ev(0, 700, t1);
        chk("rst2_first_os", t1 - r0, 651);
        wait_ev(0, 700, t2);
        chk("rst2_period", t2 - t1, 651);

        // Enable low for 5 cycles
        step(3);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("dis_no_tick", tick_os, 0);
        end
        chk("dis_phase0", os_phase, 0);
        en = 1'b1;
        r0 = cyc_cnt;
        wait_ev(0, 700, t1);
        chk("en_first_os", t1 - r0, 651);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
